// File: rtl/counter_burst_arbiter.sv
// Round-robin arbiter and burst sequencer for one shared up-counter.
// Two requesters each ask for a burst of N counts. One owner at a time sees
// data step through 0..N-1, one value per clock, followed by a one-cycle done
// pulse. A length input of 0 means a burst of 2^WIDTH counts.
//
// Ports:
//   clock  - sole clock, posedge
//   clear  - asynchronous active-high reset
//   req    - level request per requester (bit 0 = requester 0)
//   len0   - burst length for requester 0 (0 -> 2^WIDTH)
//   len1   - burst length for requester 1 (0 -> 2^WIDTH)
//   grant  - one-hot owner of data, 00 when no owner
//   busy   - high while a burst runs and during its completion cycle
//   done   - one-cycle completion pulse to the owner
//   data   - shared count value
module counter_burst_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] data
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic             ptr_q;    // favoured requester when both request
  logic             owner_q;  // requester holding the current burst
  logic [WIDTH-1:0] lim_q;    // last count of the burst, len - 1

  logic             pick;
  logic [WIDTH-1:0] pick_len;

  // Arbitration decision for the IDLE state; only used when req != 00.
  always_comb begin
    pick = ptr_q;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      default: pick = ptr_q;
    endcase
    pick_len = pick ? len1 : len0;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= StIdle;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      lim_q   <= '0;
      grant   <= 2'b00;
      busy    <= 1'b0;
      done    <= 2'b00;
      data    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req != 2'b00) begin
            owner_q <= pick;
            // Length 0 wraps to all-ones, giving a full 2^WIDTH burst.
            lim_q   <= pick_len - WIDTH'(1);
            data    <= '0;
            grant   <= pick ? 2'b10 : 2'b01;
            busy    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (!req[owner_q]) begin
            // Owner withdrew: abort silently, data keeps its last value.
            grant   <= 2'b00;
            busy    <= 1'b0;
            ptr_q   <= ~owner_q;
            state_q <= StIdle;
          end else if (data == lim_q) begin
            grant   <= 2'b00;
            done    <= grant;
            ptr_q   <= ~owner_q;
            state_q <= StDone;
          end else begin
            data <= data + WIDTH'(1);
          end
        end
        StDone: begin
          done    <= 2'b00;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          grant   <= 2'b00;
          busy    <= 1'b0;
          done    <= 2'b00;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_burst_arbiter.sv
module tb_counter_burst_arbiter;

  localparam int unsigned WIDTH = 4;

  logic             clock;
  logic             clear;
  logic [1:0]       req;
  logic [WIDTH-1:0] len0;
  logic [WIDTH-1:0] len1;
  logic [1:0]       grant;
  logic             busy;
  logic [1:0]       done;
  logic [WIDTH-1:0] data;

  counter_burst_arbiter #(.WIDTH(WIDTH)) dut (
    .clock(clock),
    .clear(clear),
    .req  (req),
    .len0 (len0),
    .len1 (len1),
    .grant(grant),
    .busy (busy),
    .done (done),
    .data (data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]       req;
    logic [WIDTH-1:0] len0;
    logic [WIDTH-1:0] len1;
    logic [1:0]       grant;
    logic             busy;
    logic [1:0]       done;
    logic [WIDTH-1:0] data;
  } vec_t;

  typedef struct {
    string            name;
    logic [1:0]       grant;
    logic             busy;
    logic [1:0]       done;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   errors;

  task automatic compare(input string name, input logic [1:0] g, input logic b,
                         input logic [1:0] d, input logic [WIDTH-1:0] v);
    checks++;
    if (grant !== g || busy !== b || done !== d || data !== v) begin
      errors++;
      $display("FAIL %s: got grant=%b busy=%b done=%b data=%0d, want grant=%b busy=%b done=%b data=%0d",
               name, grant, busy, done, data, g, b, d, v);
    end
  endtask

  // Drive one cycle of stimulus on the falling edge, queue the expected
  // post-edge outputs, then check them just after the rising edge.
  task automatic step(input string name, input logic [1:0] r, input logic [WIDTH-1:0] l0,
                      input logic [WIDTH-1:0] l1, input logic [1:0] g, input logic b,
                      input logic [1:0] d, input logic [WIDTH-1:0] v);
    exp_t e;
    exp_t got;
    @(negedge clock);
    req  = r;
    len0 = l0;
    len1 = l1;
    e.name = name; e.grant = g; e.busy = b; e.done = d; e.data = v;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got data=%0d want an entry", name, data);
    end else begin
      got = sb_q.pop_front();
      compare(got.name, got.grant, got.busy, got.done, got.data);
    end
  endtask

  vec_t vecs[21];

  initial begin
    checks = 0;
    errors = 0;

    //            req    l0 l1  grant  busy  done   data
    vecs[0]  = '{2'b11, 3, 4, 2'b01, 1'b1, 2'b00, 0};  // first grant after clear: ptr=0
    vecs[1]  = '{2'b00, 3, 4, 2'b00, 1'b0, 2'b00, 0};  // abort, ptr -> 1
    vecs[2]  = '{2'b01, 3, 4, 2'b01, 1'b1, 2'b00, 0};  // single burst len 3
    vecs[3]  = '{2'b01, 3, 4, 2'b01, 1'b1, 2'b00, 1};
    vecs[4]  = '{2'b01, 3, 4, 2'b01, 1'b1, 2'b00, 2};
    vecs[5]  = '{2'b01, 3, 4, 2'b00, 1'b1, 2'b01, 2};  // done to requester 0
    vecs[6]  = '{2'b00, 3, 4, 2'b00, 1'b0, 2'b00, 2};  // busy falls, data holds
    vecs[7]  = '{2'b11, 2, 4, 2'b10, 1'b1, 2'b00, 0};  // contention, ptr=1
    vecs[8]  = '{2'b11, 2, 4, 2'b10, 1'b1, 2'b00, 1};
    vecs[9]  = '{2'b11, 2, 4, 2'b10, 1'b1, 2'b00, 2};
    vecs[10] = '{2'b11, 2, 4, 2'b10, 1'b1, 2'b00, 3};
    vecs[11] = '{2'b11, 2, 4, 2'b00, 1'b1, 2'b10, 3};
    vecs[12] = '{2'b11, 2, 4, 2'b00, 1'b0, 2'b00, 3};  // turnaround idle cycle
    vecs[13] = '{2'b11, 2, 4, 2'b01, 1'b1, 2'b00, 0};  // fairness: requester 0 now
    vecs[14] = '{2'b11, 2, 4, 2'b01, 1'b1, 2'b00, 1};
    vecs[15] = '{2'b11, 2, 4, 2'b00, 1'b1, 2'b01, 1};
    vecs[16] = '{2'b11, 2, 4, 2'b00, 1'b0, 2'b00, 1};
    vecs[17] = '{2'b11, 2, 4, 2'b10, 1'b1, 2'b00, 0};  // back to requester 1
    vecs[18] = '{2'b11, 2, 1, 2'b10, 1'b1, 2'b00, 1};  // len change ignored mid-burst
    vecs[19] = '{2'b10, 2, 1, 2'b10, 1'b1, 2'b00, 2};  // non-owner req ignored
    vecs[20] = '{2'b00, 2, 1, 2'b00, 1'b0, 2'b00, 2};  // abort, ptr -> 0

    // Reset held for 3 clocks with both requesting.
    clear = 1'b1;
    req   = 2'b11;
    len0  = 3;
    len1  = 4;
    #1;
    compare("reset_now", 2'b00, 1'b0, 2'b00, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      compare($sformatf("reset_hold%0d", i), 2'b00, 1'b0, 2'b00, 0);
    end
    clear = 1'b0;

    for (int i = 0; i < 21; i++) begin
      step($sformatf("vec%0d", i), vecs[i].req, vecs[i].len0, vecs[i].len1,
           vecs[i].grant, vecs[i].busy, vecs[i].done, vecs[i].data);
    end

    // Length 0 on requester 1: full 16-count burst.
    for (int i = 0; i < 16; i++) begin
      step($sformatf("len0_cnt%0d", i), 2'b10, 5, 0, 2'b10, 1'b1, 2'b00, WIDTH'(i));
    end
    step("len0_done", 2'b10, 5, 0, 2'b00, 1'b1, 2'b10, 15);
    step("len0_idle", 2'b00, 5, 0, 2'b00, 1'b0, 2'b00, 15);

    // Abort at data=3 with requester 1 pending, which is served next.
    for (int i = 0; i < 4; i++) begin
      step($sformatf("abort_cnt%0d", i), 2'b01, 8, 2, 2'b01, 1'b1, 2'b00, WIDTH'(i));
    end
    step("abort_drop", 2'b10, 8, 2, 2'b00, 1'b0, 2'b00, 3);
    step("abort_next0", 2'b10, 8, 2, 2'b10, 1'b1, 2'b00, 0);
    step("abort_next1", 2'b10, 8, 2, 2'b10, 1'b1, 2'b00, 1);
    step("abort_nextdone", 2'b10, 8, 2, 2'b00, 1'b1, 2'b10, 1);
    step("abort_idle", 2'b00, 8, 2, 2'b00, 1'b0, 2'b00, 1);

    // Mid-burst asynchronous clear during a len 5 burst.
    for (int i = 0; i < 3; i++) begin
      step($sformatf("midrst_cnt%0d", i), 2'b01, 5, 2, 2'b01, 1'b1, 2'b00, WIDTH'(i));
    end
    @(negedge clock);
    #1;
    clear = 1'b1;
    req   = 2'b00;
    #1;
    compare("midrst_async", 2'b00, 1'b0, 2'b00, 0);
    #2;
    clear = 1'b0;
    step("midrst_fresh0", 2'b01, 5, 2, 2'b01, 1'b1, 2'b00, 0);
    step("midrst_fresh1", 2'b01, 5, 2, 2'b01, 1'b1, 2'b00, 1);
    step("midrst_abort", 2'b00, 5, 2, 2'b00, 1'b0, 2'b00, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
